// File: rtl/dbus_common_pkg.sv
// Data-bus transaction types shared by the pipeline core and every bus responder.
package dbus_common_pkg;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
    logic [2:0]  size;
    logic [7:0]  strobe;
    logic [63:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [63:0] data;
  } dbus_resp_t;

endpackage

// File: rtl/dbus_sram_responder_pkg.sv
// Local types and constants for the fixed-latency SRAM responder.
package dbus_sram_responder_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } dbus_resp_state_t;

  localparam int          DBUS_LAT_W       = 4;
  localparam logic [63:0] MEM_BASE_DEFAULT = 64'h8000_0000;

endpackage

// File: rtl/strobe_sram.sv
// 64-bit-word array with one combinational read port and one byte-enabled write port.
module strobe_sram #(
  parameter int WORDS = 1024,
  parameter int IDX_W = $clog2(WORDS)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IDX_W-1:0] widx,
  input  logic [7:0]       wbe,
  input  logic [63:0]      wdata,
  input  logic [IDX_W-1:0] ridx,
  output logic [63:0]      rdata
);

  logic [63:0] mem [WORDS];

  // Contents are deliberately never cleared; reset leaves the array intact.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 8; i++) begin
        if (wbe[i]) mem[widx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = mem[ridx];

endmodule

// File: rtl/dbus_sram_responder.sv
// Fixed-latency data-bus responder: latches one request, answers after LATENCY cycles,
// and merges byte-strobed writes into the SRAM in the response cycle.
module dbus_sram_responder
  import dbus_common_pkg::*;
  import dbus_sram_responder_pkg::*;
#(
  parameter int          MEM_WORDS = 1024,
  parameter logic [63:0] BASE_ADDR = MEM_BASE_DEFAULT,
  parameter int          LATENCY   = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  dbus_req_t  dreq,
  output dbus_resp_t dresp,
  output logic       err
);

  localparam int IDX_W = $clog2(MEM_WORDS);

  dbus_resp_state_t        state, state_nx;
  logic [DBUS_LAT_W-1:0]   cnt, cnt_nx;
  logic [63:0]             addr_q;
  logic [7:0]              strobe_q;
  logic [63:0]             data_q;
  logic [63:0]             off;
  logic                    in_range;
  logic                    resp_fire;
  logic                    we;
  logic [IDX_W-1:0]        idx;
  logic [63:0]             rdata;
  logic                    accept;
  logic                    unused_bits;

  // Size and the byte offset within a word never affect which word is addressed.
  assign unused_bits = ^{dreq.size, off[2:0]};

  assign accept = (state == IDLE) && dreq.valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      addr_q   <= dreq.addr;
      strobe_q <= dreq.strobe;
      data_q   <= dreq.data;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    unique case (state)
      IDLE: begin
        if (dreq.valid) begin
          cnt_nx   = DBUS_LAT_W'(LATENCY - 1);
          state_nx = (LATENCY == 1) ? RESP : WAIT;
        end
      end
      WAIT: begin
        if (cnt <= DBUS_LAT_W'(1)) state_nx = RESP;
        else                       cnt_nx   = cnt - DBUS_LAT_W'(1);
      end
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Range check works on the latched address so mid-transaction request changes are ignored.
  assign off      = addr_q - BASE_ADDR;
  assign in_range = (addr_q >= BASE_ADDR) && (off[63:IDX_W+3] == '0);
  assign idx      = off[IDX_W+2:3];

  assign resp_fire = (state == RESP);
  assign we        = resp_fire && in_range && (strobe_q != 8'h00) && !reset;

  strobe_sram #(
    .WORDS (MEM_WORDS),
    .IDX_W (IDX_W)
  ) u_sram (
    .clk   (clk),
    .we    (we),
    .widx  (idx),
    .wbe   (strobe_q),
    .wdata (data_q),
    .ridx  (idx),
    .rdata (rdata)
  );

  always_comb begin
    dresp         = '0;
    dresp.addr_ok = resp_fire;
    dresp.data_ok = resp_fire;
    dresp.data    = (resp_fire && in_range) ? rdata : 64'h0;
    err           = resp_fire && !in_range;
  end

endmodule

// File: tb/tb_dbus_sram_responder.sv
// Randomised self-checking bench for dbus_sram_responder against a word-array reference model.
module tb_dbus_sram_responder;
  import dbus_common_pkg::*;

  localparam logic [63:0] BASE   = 64'h8000_0000;
  localparam int          WORDS  = 1024;
  localparam int          SWORDS = 64;

  logic       clk;
  logic       reset;
  dbus_req_t  dreq2, dreq1, dreq15;
  dbus_resp_t resp2, resp1, resp15;
  logic       err2, err1, err15;

  int n_cmp;
  int n_fail;

  logic [63:0] mdl [WORDS];

  dbus_sram_responder #(.MEM_WORDS(WORDS), .BASE_ADDR(BASE), .LATENCY(2)) u_dut2 (
    .clk(clk), .reset(reset), .dreq(dreq2), .dresp(resp2), .err(err2));
  dbus_sram_responder #(.MEM_WORDS(SWORDS), .BASE_ADDR(BASE), .LATENCY(1)) u_dut1 (
    .clk(clk), .reset(reset), .dreq(dreq1), .dresp(resp1), .err(err1));
  dbus_sram_responder #(.MEM_WORDS(SWORDS), .BASE_ADDR(BASE), .LATENCY(15)) u_dut15 (
    .clk(clk), .reset(reset), .dreq(dreq15), .dresp(resp15), .err(err15));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic in_rng(input logic [63:0] a);
    return (a >= BASE) && (a < BASE + 64'(8 * WORDS));
  endfunction

  function automatic int widx(input logic [63:0] a);
    return int'((a - BASE) / 8);
  endfunction

  function automatic logic [63:0] exp_read(input logic [63:0] a);
    return in_rng(a) ? mdl[widx(a)] : 64'h0;
  endfunction

  function automatic void mdl_write(input logic [63:0] a, input logic [7:0] s, input logic [63:0] d);
    if (in_rng(a)) begin
      for (int i = 0; i < 8; i++)
        if (s[i]) mdl[widx(a)][8*i +: 8] = d[8*i +: 8];
    end
  endfunction

  // Drives one request on the LATENCY=2 instance, scrambling the request after acceptance.
  task automatic do_txn(input logic [63:0] a, input logic [7:0] s, input logic [63:0] d,
                        output logic [63:0] rd, output logic e, output int lat, output logic extra);
    dreq2.valid  = 1'b1;
    dreq2.addr   = a;
    dreq2.size   = 3'($urandom);
    dreq2.strobe = s;
    dreq2.data   = d;
    lat = -1; rd = '0; e = 1'b0; extra = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      dreq2.valid  = 1'b0;
      dreq2.addr   = {$urandom, $urandom};
      dreq2.strobe = 8'($urandom);
      dreq2.data   = {$urandom, $urandom};
      if (resp2.data_ok === 1'b1) begin
        lat = k; rd = resp2.data; e = err2;
        break;
      end
    end
    if (lat > 0) begin
      tick();
      extra = resp2.data_ok | resp2.addr_ok | err2;
    end
  endtask

  task automatic test_reset();
    logic [63:0] rd; logic e; int lat; logic extra;
    reset = 1'b1;
    dreq1 = '0; dreq15 = '0;
    dreq2.valid = 1'b1; dreq2.addr = BASE + 64'h10; dreq2.size = 3'd3;
    dreq2.strobe = 8'hFF; dreq2.data = 64'h1122334455667788;
    for (int c = 0; c < 2; c++) begin
      tick();
      n_cmp++;
      if ({resp2, err2} !== '0) begin
        n_fail++; $display("FAIL reset_outputs_l2: got %h expected 0", {resp2, err2});
      end
      n_cmp++;
      if ({resp1, err1, resp15, err15} !== '0) begin
        n_fail++; $display("FAIL reset_outputs_l1_l15: got %h expected 0", {resp1, err1, resp15, err15});
      end
    end
    reset = 1'b0;
    do_txn(BASE + 64'h10, 8'hFF, 64'h1122334455667788, rd, e, lat, extra);
    mdl_write(BASE + 64'h10, 8'hFF, 64'h1122334455667788);
    n_cmp++;
    if (lat !== 2) begin n_fail++; $display("FAIL first_write_latency: got %0d expected 2", lat); end
    n_cmp++;
    if (e !== 1'b0 || extra !== 1'b0) begin
      n_fail++; $display("FAIL first_write_flags: err=%b extra=%b expected 0 0", e, extra);
    end
  endtask

  task automatic test_write_read();
    logic [63:0] rd; logic e; int lat; logic extra;
    do_txn(BASE + 64'h10, 8'h00, 64'hDEAD_BEEF_0000_0000, rd, e, lat, extra);
    n_cmp++;
    if (rd !== 64'h1122334455667788) begin
      n_fail++; $display("FAIL read_back: got %h expected 1122334455667788", rd);
    end
    n_cmp++;
    if (lat !== 2 || e !== 1'b0 || extra !== 1'b0) begin
      n_fail++; $display("FAIL read_back_timing: lat=%0d err=%b extra=%b expected 2 0 0", lat, e, extra);
    end
  endtask

  task automatic test_partial();
    logic [63:0] rd; logic e; int lat; logic extra;
    do_txn(BASE + 64'h10, 8'h0F, 64'hAAAAAAAABBBBBBBB, rd, e, lat, extra);
    n_cmp++;
    if (rd !== 64'h1122334455667788) begin
      n_fail++; $display("FAIL partial_write_old_data: got %h expected 1122334455667788", rd);
    end
    do_txn(BASE + 64'h10, 8'h00, 64'h0, rd, e, lat, extra);
    n_cmp++;
    if (rd !== 64'h11223344BBBBBBBB) begin
      n_fail++; $display("FAIL partial_merge: got %h expected 11223344bbbbbbbb", rd);
    end
    do_txn(BASE + 64'h13, 8'h00, 64'h5555_6666_7777_8888, rd, e, lat, extra);
    do_txn(BASE + 64'h10, 8'h00, 64'h0, rd, e, lat, extra);
    n_cmp++;
    if (rd !== 64'h11223344BBBBBBBB) begin
      n_fail++; $display("FAIL zero_strobe_no_write: got %h expected 11223344bbbbbbbb", rd);
    end
    mdl_write(BASE + 64'h10, 8'h0F, 64'hAAAAAAAABBBBBBBB);
  endtask

  task automatic test_out_of_range();
    logic [63:0] rd; logic e; int lat; logic extra;
    logic [63:0] oor [2];
    logic [63:0] last;
    oor[0] = 64'h7FFF_FFF8;
    oor[1] = BASE + 64'(8 * WORDS);
    last   = BASE + 64'(8 * (WORDS - 1));
    do_txn(BASE, 8'hFF, 64'h0F0F_0000_1234_5678, rd, e, lat, extra);
    mdl_write(BASE, 8'hFF, 64'h0F0F_0000_1234_5678);
    do_txn(last, 8'hFF, 64'hCAFE_F00D_0BAD_BEEF, rd, e, lat, extra);
    mdl_write(last, 8'hFF, 64'hCAFE_F00D_0BAD_BEEF);
    for (int i = 0; i < 2; i++) begin
      do_txn(oor[i], 8'h00, 64'h0, rd, e, lat, extra);
      n_cmp++;
      if (rd !== 64'h0 || e !== 1'b1 || lat !== 2) begin
        n_fail++; $display("FAIL oor_read_%0d: data=%h err=%b lat=%0d expected 0 1 2", i, rd, e, lat);
      end
      do_txn(oor[i], 8'hFF, {$urandom, $urandom}, rd, e, lat, extra);
      n_cmp++;
      if (rd !== 64'h0 || e !== 1'b1 || extra !== 1'b0) begin
        n_fail++; $display("FAIL oor_write_%0d: data=%h err=%b extra=%b expected 0 1 0", i, rd, e, extra);
      end
    end
    do_txn(BASE, 8'h00, 64'h0, rd, e, lat, extra);
    n_cmp++;
    if (rd !== exp_read(BASE) || e !== 1'b0) begin
      n_fail++; $display("FAIL word0_intact: data=%h err=%b expected %h 0", rd, e, exp_read(BASE));
    end
    do_txn(last, 8'h00, 64'h0, rd, e, lat, extra);
    n_cmp++;
    if (rd !== exp_read(last) || e !== 1'b0) begin
      n_fail++; $display("FAIL last_word_intact: data=%h err=%b expected %h 0", rd, e, exp_read(last));
    end
  endtask

  task automatic test_reset_mid();
    logic [63:0] rd; logic e; int lat; logic extra;
    logic seen;
    dreq2.valid = 1'b1; dreq2.addr = BASE + 64'h10; dreq2.size = 3'd3;
    dreq2.strobe = 8'hFF; dreq2.data = 64'hFFFF_EEEE_DDDD_CCCC;
    tick();
    dreq2.valid = 1'b0;
    reset = 1'b1;
    seen = resp2.data_ok;
    tick();
    seen |= resp2.data_ok;
    reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      seen |= resp2.data_ok;
    end
    n_cmp++;
    if (seen !== 1'b0) begin n_fail++; $display("FAIL reset_mid_no_data_ok: got %b expected 0", seen); end
    do_txn(BASE + 64'h10, 8'h00, 64'h0, rd, e, lat, extra);
    n_cmp++;
    if (rd !== exp_read(BASE + 64'h10)) begin
      n_fail++; $display("FAIL reset_mid_no_commit: got %h expected %h", rd, exp_read(BASE + 64'h10));
    end
  endtask

  task automatic test_random();
    logic [63:0] rd; logic e; int lat; logic extra;
    logic [63:0] a, d, ed;
    logic [7:0]  s;
    int          ix, r;
    for (int p = 0; p <= 16; p++) begin
      ix = (p == 16) ? WORDS - 1 : p;
      a  = BASE + 64'(ix * 8);
      d  = {$urandom, $urandom};
      do_txn(a, 8'hFF, d, rd, e, lat, extra);
      mdl_write(a, 8'hFF, d);
    end
    for (int n = 0; n < 60; n++) begin
      r = $urandom_range(0, 9);
      if (r == 0) begin
        case ($urandom_range(0, 3))
          0: a = BASE - 64'd8;
          1: a = BASE + 64'(8 * WORDS);
          2: a = BASE + 64'(8 * WORDS) + 64'($urandom_range(0, 4095));
          default: a = 64'($urandom_range(0, 65535));
        endcase
      end else begin
        ix = $urandom_range(0, 16);
        if (ix == 16) ix = WORDS - 1;
        a = BASE + 64'(ix * 8) + 64'($urandom_range(0, 7));
      end
      s  = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom);
      d  = {$urandom, $urandom};
      ed = exp_read(a);
      do_txn(a, s, d, rd, e, lat, extra);
      mdl_write(a, s, d);
      n_cmp++;
      if (rd !== ed || e !== !in_rng(a) || lat !== 2 || extra !== 1'b0) begin
        n_fail++;
        $display("FAIL random_%0d addr=%h strb=%h: data=%h err=%b lat=%0d extra=%b expected %h %b 2 0",
                 n, a, s, rd, e, lat, extra, ed, !in_rng(a));
      end
    end
  endtask

  task automatic test_back_to_back();
    logic ok2, ok1, ok15;
    dreq1.valid = 1'b1;  dreq1.addr = BASE + 64'h20;  dreq1.strobe = 8'h00;
    dreq15.valid = 1'b1; dreq15.addr = BASE + 64'h28; dreq15.strobe = 8'h00;
    dreq2.valid = 1'b1;  dreq2.addr = BASE + 64'h30;  dreq2.strobe = 8'h00;
    for (int t = 1; t <= 100; t++) begin
      tick();
      ok1  = (t >= 1)  && ((t - 1)  % 2  == 0);
      ok2  = (t >= 2)  && ((t - 2)  % 3  == 0);
      ok15 = (t >= 15) && ((t - 15) % 16 == 0);
      n_cmp++;
      if (resp1.data_ok !== ok1) begin
        n_fail++; $display("FAIL b2b_lat1 t=%0d: data_ok=%b expected %b", t, resp1.data_ok, ok1);
      end
      n_cmp++;
      if (resp2.data_ok !== ok2) begin
        n_fail++; $display("FAIL b2b_lat2 t=%0d: data_ok=%b expected %b", t, resp2.data_ok, ok2);
      end
      n_cmp++;
      if (resp15.data_ok !== ok15) begin
        n_fail++; $display("FAIL b2b_lat15 t=%0d: data_ok=%b expected %b", t, resp15.data_ok, ok15);
      end
    end
    dreq1.valid = 1'b0; dreq15.valid = 1'b0; dreq2.valid = 1'b0;
    repeat (20) tick();
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    reset = 1'b1;
    dreq1 = '0; dreq2 = '0; dreq15 = '0;
    test_reset();
    test_write_read();
    test_partial();
    test_out_of_range();
    test_reset_mid();
    test_random();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
